// File: rtl/uart_rx_ctrl_if.sv
// Bundle of line, sampler and status signals around the UART receive frame controller.
// master: the frame controller. slave: the line/sampler/deserializer side.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
);
  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);

  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Sampled_Bit;
  logic                  Sample_Valid;

  logic                  Sampler_EN;
  logic                  Deser_EN;
  logic [PRESCALE_W-1:0] Edge_Cnt;
  logic [BIT_CNT_W-1:0]  Bit_Cnt;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;
  logic                  Strt_Glitch;

  modport master (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP, Sampled_Bit, Sample_Valid,
    output Sampler_EN, Deser_EN, Edge_Cnt, Bit_Cnt, Data_Valid, Par_Err, Stp_Err, Strt_Glitch
  );

  modport slave (
    output RX_IN, Prescale, PAR_EN, PAR_TYP, Sampled_Bit, Sample_Valid,
    input  Sampler_EN, Deser_EN, Edge_Cnt, Bit_Cnt, Data_Valid, Par_Err, Stp_Err, Strt_Glitch
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, per-bit timing at the oversampling rate,
// sampler/deserializer enables, start/parity/stop checking and the Data_Valid strobe.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined; otherwise frames
// are start + DATA_WIDTH data bits + stop, and Par_Err is tied low.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input logic            Deseralizer_CLK,
  input logic            Deseralizer_RST,
  uart_rx_ctrl_if.master rx_if
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  sample_q, sample_d;
  logic                  stp_err_q, stp_err_d;
  logic                  data_valid_q, data_valid_d;
  logic                  strt_glitch_q, strt_glitch_d;

  logic                  bit_end;
  logic                  bit_sample;
  logic                  par_err;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic parity_q, parity_d;
  logic par_err_q, par_err_d;

  assign par_err = par_err_q;
`else
  logic unused_par_cfg;

  assign unused_par_cfg = rx_if.PAR_EN ^ rx_if.PAR_TYP;
  assign par_err        = 1'b0;
`endif

  // Bit boundary uses the prescale captured at start detection, not the live input.
  assign bit_end = (state_q != StIdle) && (edge_cnt_q == (p_q - PRESCALE_W'(1)));

  // A strobe arriving on the bit-end cycle itself is the latest sample of that bit.
  assign bit_sample = rx_if.Sample_Valid ? rx_if.Sampled_Bit : sample_q;

  // Next-state, counters and flag updates.
  always_comb begin
    state_d       = state_q;
    edge_cnt_d    = edge_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    p_d           = p_q;
    sample_d      = sample_q;
    stp_err_d     = stp_err_q;
    data_valid_d  = 1'b0;
    strt_glitch_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    parity_d      = parity_q;
    par_err_d     = par_err_q;
`endif

    // Edge counter and per-bit sample latch; the latch re-arms to 1 at every bit boundary.
    if (state_q == StIdle) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      sample_d   = 1'b1;
    end else if (bit_end) begin
      edge_cnt_d = '0;
      sample_d   = 1'b1;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      sample_d   = bit_sample;
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_if.RX_IN) begin
          state_d   = StStart;
          p_d       = rx_if.Prescale;
          stp_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_en_d  = rx_if.PAR_EN;
          par_typ_d = rx_if.PAR_TYP;
          parity_d  = 1'b0;
          par_err_d = 1'b0;
`endif
        end
      end

      StStart: begin
        if (bit_end) begin
          if (bit_sample) begin
            strt_glitch_d = 1'b1;
            state_d       = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
`ifdef UART_RX_PARITY_EN
        if (rx_if.Sample_Valid) begin
          parity_d = parity_q ^ rx_if.Sampled_Bit;
        end
`endif
        if (bit_end) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = par_en_q ? StParity : StStop;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          par_err_d = bit_sample != (parity_q ^ par_typ_q);
          state_d   = StStop;
        end
      end
`endif

      StStop: begin
        if (bit_end) begin
          stp_err_d    = ~bit_sample;
          data_valid_d = bit_sample & ~par_err;
          state_d      = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and flag registers; reset drops any frame in progress.
  always_ff @(posedge Deseralizer_CLK or negedge Deseralizer_RST) begin
    if (!Deseralizer_RST) begin
      state_q       <= StIdle;
      edge_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      p_q           <= '0;
      sample_q      <= 1'b1;
      stp_err_q     <= 1'b0;
      data_valid_q  <= 1'b0;
      strt_glitch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      p_q           <= p_d;
      sample_q      <= sample_d;
      stp_err_q     <= stp_err_d;
      data_valid_q  <= data_valid_d;
      strt_glitch_q <= strt_glitch_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Per-frame parity configuration, running parity and the parity error flag.
  always_ff @(posedge Deseralizer_CLK or negedge Deseralizer_RST) begin
    if (!Deseralizer_RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      parity_q  <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      parity_q  <= parity_d;
      par_err_q <= par_err_d;
    end
  end
`endif

  // Enables decoded from the registered state only, so they cannot glitch.
  assign rx_if.Sampler_EN  = (state_q != StIdle);
  assign rx_if.Deser_EN    = (state_q == StData);
  assign rx_if.Edge_Cnt    = edge_cnt_q;
  assign rx_if.Bit_Cnt     = bit_cnt_q;
  assign rx_if.Data_Valid  = data_valid_q;
  assign rx_if.Par_Err     = par_err;
  assign rx_if.Stp_Err     = stp_err_q;
  assign rx_if.Strt_Glitch = strt_glitch_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frames are described as records, expanded into a per-cycle line,
// sampler-strobe and expected-output timeline from frame arithmetic, then played cycle by cycle.
module tb_uart_rx_ctrl;
  localparam int unsigned DW   = 8;
  localparam int unsigned PW   = 6;
  localparam int          MAXC = 8192;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic Deseralizer_CLK;
  logic Deseralizer_RST;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) rx_if ();

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .Deseralizer_CLK(Deseralizer_CLK),
    .Deseralizer_RST(Deseralizer_RST),
    .rx_if          (rx_if)
  );

  initial begin
    Deseralizer_CLK = 1'b0;
    forever #5 Deseralizer_CLK = ~Deseralizer_CLK;
  end

  // Stand-in for the external deserializer: LSB-first shift on enabled strobes.
  logic [7:0] deser = '0;
  always @(posedge Deseralizer_CLK) begin
    if (rx_if.Deser_EN && rx_if.Sample_Valid) deser <= {rx_if.Sampled_Bit, deser[7:1]};
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp, input int cyc);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // stop_mode: 0 one strobe per stop bit, 1 extra early strobe of the wrong value, 2 no strobe.
  typedef struct {
    int       p;
    bit       pe;
    bit       pt;
    bit [7:0] data;
    bit       par_bit;
    bit       stop;
    int       stop_mode;
    int       glitch;
    int       gap;
    bit       exp_dv;
    bit       exp_pe;
    bit       exp_se;
  } frame_t;

  function automatic frame_t mk(input int p, input bit pe, input bit pt, input bit [7:0] data,
                                input bit par_bit, input bit stop, input int stop_mode,
                                input int glitch, input int gap, input bit dv, input bit perr,
                                input bit serr);
    frame_t f;
    f.p = p; f.pe = pe; f.pt = pt; f.data = data; f.par_bit = par_bit; f.stop = stop;
    f.stop_mode = stop_mode; f.glitch = glitch; f.gap = gap;
    f.exp_dv = dv; f.exp_pe = perr; f.exp_se = serr;
    return f;
  endfunction

  // Reference outcome of one frame from the UART framing rules.
  function automatic frame_t ref_frame(input frame_t f);
    int ones;
    bit par_ok;
    bit stop_seen;
    ones = 0;
    for (int b = 0; b < 8; b++) ones += int'(f.data[b]);
    par_ok    = ((ones + int'(f.par_bit)) % 2) == int'(f.pt);
    stop_seen = (f.stop_mode == 2) ? 1'b1 : f.stop;
    if (f.glitch > 0) begin
      f.exp_pe = 1'b0; f.exp_se = 1'b0; f.exp_dv = 1'b0;
    end else begin
      f.exp_pe = HAS_PAR && f.pe && !par_ok;
      f.exp_se = !stop_seen;
      f.exp_dv = stop_seen && !f.exp_pe;
    end
    return f;
  endfunction

  bit       s_rx [MAXC];
  bit       s_sv [MAXC];
  bit       s_sb [MAXC];
  int       s_pr [MAXC];
  bit       s_pen[MAXC];
  bit       s_pt [MAXC];
  bit       e_sen[MAXC];
  bit       e_den[MAXC];
  bit       e_dv [MAXC];
  bit       e_gl [MAXC];
  bit       e_pe [MAXC];
  bit       e_se [MAXC];
  int       e_ec [MAXC];
  int       e_bc [MAXC];
  bit [7:0] e_byte[MAXC];
  frame_t   seg[$];
  int       seg_len;

  task automatic build_seg();
    int t;
    int free_c;
    t = 0;
    free_c = 0;
    for (int c = 0; c < MAXC; c++) begin
      s_rx[c] = 1'b1; s_sv[c] = 1'b0; s_sb[c] = 1'($urandom);
      s_pr[c] = 4 + 2 * $urandom_range(0, 14); s_pen[c] = 1'($urandom); s_pt[c] = 1'($urandom);
      e_sen[c] = 0; e_den[c] = 0; e_dv[c] = 0; e_gl[c] = 0; e_pe[c] = 0; e_se[c] = 0;
      e_ec[c] = 0; e_bc[c] = 0; e_byte[c] = '0;
    end
    foreach (seg[i]) begin
      frame_t f;
      int p, s, e0, n;
      bit pe_eff;
      bit v;
      f = seg[i];
      p = f.p;
      t += f.gap;
      s = t;
      // The controller only re-arms one cycle after the previous frame ends.
      e0 = (s > free_c) ? s : free_c;
      s_pr[e0] = p; s_pen[e0] = f.pe; s_pt[e0] = f.pt;
      if (f.glitch > 0) begin
        for (int c = s; c < s + p; c++) s_rx[c] = (c >= s + f.glitch);
        s_sv[s + p / 2] = 1'b1;
        s_sb[s + p / 2] = s_rx[s + p / 2];
        for (int j = 0; j < p; j++) begin
          e_sen[e0 + j] = 1'b1;
          e_ec[e0 + j]  = j;
        end
        e_gl[e0 + p] = 1'b1;
        for (int c = e0; c < MAXC; c++) begin
          e_pe[c] = 1'b0; e_se[c] = 1'b0;
        end
        free_c = e0 + p + 1;
        t = s + p;
      end else begin
        pe_eff = HAS_PAR && f.pe;
        n = 10 + int'(pe_eff);
        for (int k = 0; k < n; k++) begin
          if (k == 0) v = 1'b0;
          else if (k <= 8) v = f.data[k - 1];
          else if (k == n - 1) v = f.stop;
          else v = f.par_bit;
          for (int c = s + k * p; c < s + (k + 1) * p; c++) s_rx[c] = v;
          if (!(k == n - 1 && f.stop_mode == 2)) begin
            s_sv[s + k * p + p / 2] = 1'b1;
            s_sb[s + k * p + p / 2] = v;
          end
          if (k == n - 1 && f.stop_mode == 1) begin
            s_sv[s + k * p + 1] = 1'b1;
            s_sb[s + k * p + 1] = ~v;
          end
        end
        for (int j = 0; j < n * p; j++) begin
          e_sen[e0 + j] = 1'b1;
          e_ec[e0 + j]  = j % p;
          if (j / p >= 1 && j / p <= 8) begin
            e_den[e0 + j] = 1'b1;
            e_bc[e0 + j]  = j / p - 1;
          end
        end
        e_dv[e0 + n * p]   = f.exp_dv;
        e_byte[e0 + n * p] = f.data;
        for (int c = e0; c < MAXC; c++) begin
          e_pe[c] = (pe_eff && c >= e0 + 10 * p) ? f.exp_pe : 1'b0;
          e_se[c] = (c >= e0 + n * p) ? f.exp_se : 1'b0;
        end
        free_c = e0 + n * p + 1;
        t = s + n * p;
      end
    end
    seg_len = ((t > free_c) ? t : free_c) + 4;
  endtask

  task automatic run_seg(input int stop_at);
    int lim;
    build_seg();
    lim = (stop_at < seg_len) ? stop_at : seg_len;
    for (int c = 0; c < lim; c++) begin
      @(negedge Deseralizer_CLK);
      rx_if.RX_IN        = s_rx[c];
      rx_if.Sample_Valid = s_sv[c];
      rx_if.Sampled_Bit  = s_sb[c];
      rx_if.Prescale     = PW'(s_pr[c]);
      rx_if.PAR_EN       = s_pen[c];
      rx_if.PAR_TYP      = s_pt[c];
      @(posedge Deseralizer_CLK);
      #1;
      chk("Sampler_EN", int'(rx_if.Sampler_EN), int'(e_sen[c]), c);
      chk("Deser_EN", int'(rx_if.Deser_EN), int'(e_den[c]), c);
      chk("Edge_Cnt", int'(rx_if.Edge_Cnt), e_ec[c], c);
      chk("Bit_Cnt", int'(rx_if.Bit_Cnt), e_bc[c], c);
      chk("Data_Valid", int'(rx_if.Data_Valid), int'(e_dv[c]), c);
      chk("Strt_Glitch", int'(rx_if.Strt_Glitch), int'(e_gl[c]), c);
      chk("Par_Err", int'(rx_if.Par_Err), int'(e_pe[c]), c);
      chk("Stp_Err", int'(rx_if.Stp_Err), int'(e_se[c]), c);
      if (e_dv[c]) chk("deser_byte", int'(deser), int'(e_byte[c]), c);
    end
    seg.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_Sampler_EN"}, int'(rx_if.Sampler_EN), 0, -1);
    chk({tag, "_Deser_EN"}, int'(rx_if.Deser_EN), 0, -1);
    chk({tag, "_Edge_Cnt"}, int'(rx_if.Edge_Cnt), 0, -1);
    chk({tag, "_Bit_Cnt"}, int'(rx_if.Bit_Cnt), 0, -1);
    chk({tag, "_Data_Valid"}, int'(rx_if.Data_Valid), 0, -1);
    chk({tag, "_Par_Err"}, int'(rx_if.Par_Err), 0, -1);
    chk({tag, "_Stp_Err"}, int'(rx_if.Stp_Err), 0, -1);
    chk({tag, "_Strt_Glitch"}, int'(rx_if.Strt_Glitch), 0, -1);
  endtask

  frame_t tbl[$];

  initial begin
    Deseralizer_RST    = 1'b0;
    rx_if.RX_IN        = 1'b1;
    rx_if.Sample_Valid = 1'b0;
    rx_if.Sampled_Bit  = 1'b0;
    rx_if.Prescale     = PW'(8);
    rx_if.PAR_EN       = 1'b0;
    rx_if.PAR_TYP      = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge Deseralizer_CLK);
    Deseralizer_RST = 1'b1;

    // p, pe, pt, data, par_bit, stop, stop_mode, glitch, gap -> dv, par_err, stp_err
    tbl.push_back(mk(8, 0, 0, 8'hA5, 0, 1, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(16, 1, 0, 8'h3C, 1, 1, 0, 0, 2, !HAS_PAR, HAS_PAR, 0));
    tbl.push_back(mk(16, 1, 0, 8'h3C, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(8, 0, 0, 8'h00, 0, 1, 0, 3, 2, 0, 0, 0));
    tbl.push_back(mk(8, 0, 0, 8'h5A, 0, 0, 0, 0, 2, 0, 0, 1));
    tbl.push_back(mk(32, 0, 0, 8'h55, 0, 1, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(32, 0, 0, 8'hFF, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(8, 0, 0, 8'h0F, 0, 0, 0, 0, 3, 0, 0, 1));
    tbl.push_back(mk(8, 0, 0, 8'h81, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4, 1, 1, 8'h07, 0, 1, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(6, 0, 0, 8'h96, 0, 1, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(10, 0, 0, 8'h3A, 0, 0, 2, 0, 2, 1, 0, 0));
    for (int i = 0; i < tbl.size(); i++) seg.push_back(tbl[i]);
    run_seg(MAXC);

    // Randomised frames with mid-frame config churn, scored by the reference outcome.
    for (int i = 0; i < 12; i++) begin
      frame_t f;
      f.p         = 4 + 2 * $urandom_range(0, 14);
      f.pe        = 1'($urandom);
      f.pt        = 1'($urandom);
      f.data      = 8'($urandom);
      f.par_bit   = 1'($urandom);
      f.stop      = ($urandom_range(0, 3) != 0);
      f.stop_mode = $urandom_range(0, 2);
      f.glitch    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, f.p / 2 - 1) : 0;
      f.gap       = $urandom_range(1, 4);
      seg.push_back(ref_frame(f));
    end
    run_seg(MAXC);

    // Reset in the middle of data bit 4, then a clean frame must still be received.
    seg.push_back(mk(8, 0, 0, 8'hC3, 0, 1, 0, 0, 1, 1, 0, 0));
    run_seg(1 + 5 * 8 + 3);
    #2;
    Deseralizer_RST = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge Deseralizer_CLK);
    rx_if.RX_IN        = 1'b1;
    rx_if.Sample_Valid = 1'b0;
    repeat (2) @(negedge Deseralizer_CLK);
    Deseralizer_RST = 1'b1;
    seg.push_back(mk(8, 0, 0, 8'h5A, 0, 1, 0, 0, 2, 1, 0, 0));
    run_seg(MAXC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
